// File: rtl/div_pkg.sv
// div_pkg: shared constants for the multi-channel clock divider.
//   CNT_W_DEF   - default counter / divisor width
//   DEF_DIV_DEF - default divisor loaded at reset
//   MIN_DIV     - smallest divisor a channel will accept
package div_pkg;

    localparam int CNT_W_DEF   = 24;
    localparam int DEF_DIV_DEF = 5000000;
    localparam int MIN_DIV     = 2;

endpackage

// File: rtl/div_channel.sv
// div_channel: one independent clock-divider channel with a shadowed divisor.
// Ports:
//   pixel_clk - clock, rising edge
//   reset     - asynchronous, active-low
//   en        - run enable; when low the counter parks at 0 and outputs are 0
//   load      - strobe capturing div_in into the shadow divisor
//   div_in    - new divisor (values below 2 are raised to 2)
//   sync      - phase-align strobe: restart the period and apply any shadow
//   clk_div   - divided clock, registered
//   tick      - one-cycle pulse at period start, registered
//   pend      - shadow divisor waiting to be applied
module div_channel
    import div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             sync,
    output logic             clk_div,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

    function automatic logic [CNT_W-1:0] sat_min_div(input logic [CNT_W-1:0] d);
        return (d < MIN_DIV_W) ? MIN_DIV_W : d;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic             wrap;
    logic             apply_now;

    assign wrap = en && (cnt == (div_act - ONE));

    // Every case that restarts the period (sync, disable, wrap) is also the
    // moment a pending shadow divisor takes over.
    assign apply_now = sync || !en || wrap;

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            div_act <= DEF_DIV_W;
            div_shd <= DEF_DIV_W;
            pend    <= 1'b0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // Outputs are decoded from the counter value sampled at this edge.
            tick    <= en && (cnt == '0);
            clk_div <= en && (cnt < (div_act >> 1));

            if (apply_now) cnt <= '0;
            else           cnt <= cnt + ONE;

            // div_act takes the old shadow, so a load coinciding with a
            // restart is held over to the next one.
            if (apply_now && pend) div_act <= div_shd;

            if (load) div_shd <= sat_min_div(div_in);

            if (load)           pend <= 1'b1;
            else if (apply_now) pend <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_divider_mc.sv
// clk_divider_mc: NUM_CH independent clock dividers sharing one sync strobe.
// Ports:
//   pixel_clk - clock, rising edge
//   reset     - asynchronous, active-low
//   en[i]     - channel i run enable
//   load[i]   - channel i divisor load strobe
//   div_in    - channel i divisor in bits [i*CNT_W +: CNT_W]
//   sync      - phase-align strobe applied to all channels
//   clk_div[i], tick[i], pend[i] - channel i outputs
module clk_divider_mc
    import div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                    pixel_clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        div_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .pixel_clk (pixel_clk),
            .reset     (reset),
            .en        (en[i]),
            .load      (load[i]),
            .div_in    (div_in[i*CNT_W +: CNT_W]),
            .sync      (sync),
            .clk_div   (clk_div[i]),
            .tick      (tick[i]),
            .pend      (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_mc.sv
// tb_clk_divider_mc: self-checking bench for clk_divider_mc.
module tb_clk_divider_mc;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 7;

    logic                    pixel_clk = 1'b0;
    logic                    reset     = 1'b0;
    logic [NUM_CH-1:0]       en        = '0;
    logic [NUM_CH-1:0]       load      = '0;
    logic [NUM_CH*CNT_W-1:0] div_in    = '0;
    logic                    sync      = 1'b0;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pend;

    clk_divider_mc #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .div_in    (div_in),
        .sync      (sync),
        .clk_div   (clk_div),
        .tick      (tick),
        .pend      (pend)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a position within a period of length
    // 'period'; a waiting divisor is held in 'next_period'.
    int                pos         [NUM_CH];
    int                period      [NUM_CH];
    int                next_period [NUM_CH];
    bit                waiting     [NUM_CH];
    logic [NUM_CH-1:0] m_clk;
    logic [NUM_CH-1:0] m_tick;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            pos[i] = 0; period[i] = DEF_DIV; next_period[i] = DEF_DIV; waiting[i] = 0;
        end
        m_clk = '0; m_tick = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            int  d;
            bit  restart;
            d = int'(div_in[i*CNT_W +: CNT_W]);
            if (d < 2) d = 2;
            m_tick[i] = en[i] && (pos[i] == 0);
            m_clk[i]  = en[i] && (pos[i] < period[i] / 2);
            restart   = sync || !en[i] || (pos[i] == period[i] - 1);
            if (restart) begin
                pos[i] = 0;
                if (waiting[i]) period[i] = next_period[i];
                waiting[i] = 0;
            end else begin
                pos[i] = pos[i] + 1;
            end
            if (load[i]) begin
                next_period[i] = d;
                waiting[i]     = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge pixel_clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic en;
        logic load;
        int   dv;
        logic e_clk;
        logic e_tick;
        logic e_pend;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit found;
        logic [1:0] exp_t;

        model_reset();

        // {en, load, div, clk_div, tick, pend} for channel 0
        vecs.push_back('{0,1,4, 0,0,1});   // load 4 while disabled
        vecs.push_back('{0,0,0, 0,0,0});   // applied during disabled cycle
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,0,0, 1,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,1,6, 1,0,1});   // load 6 at cnt=1
        vecs.push_back('{1,0,0, 0,0,1});
        vecs.push_back('{1,0,0, 0,0,0});   // wrap applies 6
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,0,0, 1,0,0});
        vecs.push_back('{1,0,0, 1,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{0,1,1, 0,0,1});   // load 1 -> 2
        vecs.push_back('{0,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,1,0, 1,1,1});   // load 0 -> 2
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,1,5, 0,0,1});   // load on the wrap edge
        vecs.push_back('{1,0,0, 1,1,1});   // still period 2
        vecs.push_back('{1,0,0, 0,0,0});   // next wrap applies 5
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{1,0,0, 1,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 0,0,0});
        vecs.push_back('{1,0,0, 1,1,0});
        vecs.push_back('{0,0,0, 0,0,0});

        // Reset state
        #3;
        check("rst_clk_div", 32'(clk_div), 32'(0));
        check("rst_tick",    32'(tick),    32'(0));
        check("rst_pend",    32'(pend),    32'(0));
        @(negedge pixel_clk);
        reset = 1'b1;
        @(negedge pixel_clk);

        // Table-driven sequences on channel 0
        foreach (vecs[k]) begin
            en[0]              = vecs[k].en;
            load[0]            = vecs[k].load;
            div_in[CNT_W-1:0]  = CNT_W'(vecs[k].dv);
            cycle();
            check($sformatf("tbl%0d_clk", k),  32'(clk_div[0]), 32'(vecs[k].e_clk));
            check($sformatf("tbl%0d_tick", k), 32'(tick[0]),    32'(vecs[k].e_tick));
            check($sformatf("tbl%0d_pend", k), 32'(pend[0]),    32'(vecs[k].e_pend));
            check($sformatf("tbl%0d_idle", k), 32'(clk_div[NUM_CH-1:1] | tick[NUM_CH-1:1]), 32'(0));
        end
        load = '0;

        // Sync alignment: ch0 div 3, ch1 div 6
        en = '0;
        load = 4'b0011;
        div_in[0*CNT_W +: CNT_W] = CNT_W'(3);
        div_in[1*CNT_W +: CNT_W] = CNT_W'(6);
        cycle();
        load = '0;
        cycle();
        en = 4'b0011;
        for (int k = 0; k < 4; k++) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            cycle();
            exp_t[0] = ((k - 1) % 3) == 0;
            exp_t[1] = ((k - 1) % 6) == 0;
            check($sformatf("sync_tick_k%0d", k), 32'(tick[1:0]), 32'(exp_t));
        end

        // Reset mid-period with a pending divisor
        load[0] = 1'b1;
        div_in[0*CNT_W +: CNT_W] = CNT_W'(9);
        cycle();
        load = '0;
        check("pre_rst_pend", 32'(pend[0]), 32'(1));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_clk_div", 32'(clk_div), 32'(0));
        check("async_rst_tick",    32'(tick),    32'(0));
        check("async_rst_pend",    32'(pend),    32'(0));
        en = '0;
        @(negedge pixel_clk);
        reset = 1'b1;
        en = 4'b0001;
        cycle();
        check("post_rst_first_tick", 32'(tick[0]),    32'(1));
        check("post_rst_first_clk",  32'(clk_div[0]), 32'(1));
        n = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            cycle();
            if (tick[0]) begin n = k; found = 1; end
        end
        check("post_rst_period", 32'(n), 32'(DEF_DIV));
        check("post_rst_pend",   32'(pend[0]), 32'(0));

        // Randomized run against the reference model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en[i]   = ($urandom_range(7) != 0);
                load[i] = ($urandom_range(15) == 0);
                div_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(12));
            end
            sync = ($urandom_range(40) == 0);
            cycle();
            check($sformatf("rnd%0d_clk", c),  32'(clk_div), 32'(m_clk));
            check($sformatf("rnd%0d_tick", c), 32'(tick),    32'(m_tick));
            begin
                logic [NUM_CH-1:0] mp;
                for (int i = 0; i < NUM_CH; i++) mp[i] = waiting[i];
                check($sformatf("rnd%0d_pend", c), 32'(pend), 32'(mp));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
